shift_add_mul32: RTL and testbench

SHIFT_ADD_MUL32 -- requirements
Module: shift_add_mul32

---
 rtl/shift_add_mul32_pkg.sv | 14 +
 rtl/shift_add_mul32_cla.sv | 52 +++++
 rtl/shift_add_mul32.sv | 87 ++++++++
 tb/tb_shift_add_mul32.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/shift_add_mul32_pkg.sv
// Shared constants and state encoding for the 32x32 shift-and-add multiplier.
package shift_add_mul32_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;
    localparam int ITER   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_mul32_cla.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups chained on group carries.
module cla_64
    import shift_add_mul32_pkg::*;
(
    input  logic [PROD_W-1:0] A,
    input  logic [PROD_W-1:0] B,
    input  logic              CIN,
    output logic [PROD_W-1:0] S,
    output logic              COUT,
    output logic              GG,
    output logic              PG
);

    logic [PROD_W-1:0] g;
    logic [PROD_W-1:0] p;
    logic [PROD_W-1:0] c;
    logic [15:0]       bg;
    logic [15:0]       bp;
    logic [16:0]       bc;
    logic              gg_acc;

    always_comb begin
        g      = A & B;
        p      = A ^ B;
        c      = '0;
        bg     = '0;
        bp     = '0;
        bc     = '0;
        gg_acc = 1'b0;
        bc[0]  = CIN;
        for (int b = 0; b < 16; b++) begin
            bg[b] = g[4*b+3]
                  | (p[4*b+3] & g[4*b+2])
                  | (p[4*b+3] & p[4*b+2] & g[4*b+1])
                  | (p[4*b+3] & p[4*b+2] & p[4*b+1] & g[4*b]);
            bp[b] = &p[4*b +: 4];
            c[4*b]   = bc[b];
            c[4*b+1] = g[4*b] | (p[4*b] & bc[b]);
            c[4*b+2] = g[4*b+1] | (p[4*b+1] & g[4*b]) | (p[4*b+1] & p[4*b] & bc[b]);
            c[4*b+3] = g[4*b+2] | (p[4*b+2] & g[4*b+1]) | (p[4*b+2] & p[4*b+1] & g[4*b])
                     | (p[4*b+2] & p[4*b+1] & p[4*b] & bc[b]);
            bc[b+1] = bg[b] | (bp[b] & bc[b]);
            // Whole-word generate is independent of CIN, so fold it separately.
            gg_acc  = bg[b] | (bp[b] & gg_acc);
        end
        S    = p ^ c;
        COUT = bc[16];
        GG   = gg_acc;
        PG   = &bp;
    end

endmodule

// File: rtl/shift_add_mul32.sv
// Sequential 32x32 unsigned multiplier: one shift-and-add step per cycle, fixed 32 steps.
module shift_add_mul32
    import shift_add_mul32_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [OP_W-1:0]   MCAND,
    input  logic [OP_W-1:0]   MPLIER,
    output logic              BUSY,
    output logic              DONE,
    output logic [PROD_W-1:0] PRODUCT
);

    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    state_t            state;
    state_t            state_nxt;
    logic [PROD_W-1:0] mcand_sh;
    logic [OP_W-1:0]   mplier_sh;
    logic [PROD_W-1:0] acc;
    logic [4:0]        cnt;
    logic [PROD_W-1:0] addend;
    logic [PROD_W-1:0] sum;

    assign addend = mplier_sh[0] ? mcand_sh : '0;

    cla_64 u_cla (
        .A    (acc),
        .B    (addend),
        .CIN  (1'b0),
        .S    (sum),
        .COUT (),
        .GG   (),
        .PG   ()
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = CALC;
            CALC:    if (cnt == LAST_CNT) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand_sh  <= '0;
            mplier_sh <= '0;
            acc       <= '0;
            cnt       <= '0;
            PRODUCT   <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            // Flags are registered from the next state so they line up with it.
            BUSY <= (state_nxt == CALC) || (state_nxt == FIN);
            DONE <= (state_nxt == FIN);
            case (state)
                IDLE: begin
                    if (START) begin
                        mcand_sh  <= {{(PROD_W-OP_W){1'b0}}, MCAND};
                        mplier_sh <= MPLIER;
                        acc       <= '0;
                        cnt       <= '0;
                    end
                end
                CALC: begin
                    acc       <= sum;
                    mcand_sh  <= mcand_sh << 1;
                    mplier_sh <= mplier_sh >> 1;
                    cnt       <= cnt + 5'd1;
                    if (cnt == LAST_CNT) PRODUCT <= sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mul32.sv
// Self-checking bench for shift_add_mul32 against a plain-arithmetic product model.
module tb_shift_add_mul32;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [31:0] MCAND;
    logic [31:0] MPLIER;
    logic        BUSY;
    logic        DONE;
    logic [63:0] PRODUCT;

    int          checks;
    int          errors;
    logic [63:0] exp_prod;

    shift_add_mul32 dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .MCAND   (MCAND),
        .MPLIER  (MPLIER),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .PRODUCT (PRODUCT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one multiply from IDLE and check every cycle until it is idle again.
    // With poke set, START is raised mid-calculation and during the DONE cycle.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input bit poke, input string tag);
        START  = 1'b1;
        MCAND  = a;
        MPLIER = b;
        @(posedge CLK); #1;
        START  = 1'b0;
        MCAND  = $urandom;
        MPLIER = $urandom;
        for (int n = 1; n <= 34; n++) begin
            @(posedge CLK); #1;
            START = 1'b0;
            if (n == 32) exp_prod = model_mul(a, b);
            check({tag, " done"}, 64'(DONE), 64'(n == 32));
            check({tag, " busy"}, 64'(BUSY), 64'(n <= 32));
            check({tag, " product"}, PRODUCT, exp_prod);
            if (poke && (n == 5 || n == 20 || n == 32)) begin
                START  = 1'b1;
                MCAND  = $urandom;
                MPLIER = $urandom;
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_prod = '0;
        RST      = 1'b1;
        START    = 1'b1;
        MCAND    = 32'hDEAD_BEEF;
        MPLIER   = 32'h1234_5678;
        repeat (3) @(posedge CLK);
        #1;
        check("reset product", PRODUCT, 64'd0);
        check("reset busy", 64'(BUSY), 64'd0);
        check("reset done", 64'(DONE), 64'd0);

        RST   = 1'b0;
        START = 1'b0;
        for (int i = 0; i < 50; i++) begin
            MCAND  = $urandom;
            MPLIER = $urandom;
            @(posedge CLK); #1;
            check("idle outputs", {PRODUCT[61:0], BUSY, DONE}, 64'd0);
        end

        run_mul(32'd7, 32'd6, 1'b0, "basic 7x6");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "max x max");
        check("max x max value", exp_prod, 64'hFFFF_FFFE_0000_0001);
        run_mul(32'd0, 32'h1234_5678, 1'b0, "zero mcand");
        run_mul(32'h8000_0000, 32'd2, 1'b0, "top bit");

        for (int i = 0; i < 6; i++) begin
            run_mul($urandom, $urandom, 1'b0, "random");
            repeat ($urandom_range(0, 3)) begin
                @(posedge CLK); #1;
                check("gap product", PRODUCT, exp_prod);
            end
        end

        run_mul(32'd3, 32'd5, 1'b1, "ignored start 3x5");

        // START held high: second multiply is accepted two edges after DONE.
        START  = 1'b1;
        MCAND  = 32'd2;
        MPLIER = 32'd3;
        @(posedge CLK); #1;
        MCAND  = 32'd4;
        MPLIER = 32'd5;
        for (int n = 1; n <= 68; n++) begin
            @(posedge CLK); #1;
            if (n == 32) exp_prod = 64'd6;
            if (n == 66) exp_prod = 64'd20;
            check("b2b done", 64'(DONE), 64'(n == 32 || n == 66));
            check("b2b busy", 64'(BUSY), 64'(!(n == 33 || n >= 67)));
            check("b2b product", PRODUCT, exp_prod);
            if (n == 66) START = 1'b0;
        end

        START  = 1'b1;
        MCAND  = 32'h0000_ABCD;
        MPLIER = 32'h0000_1234;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("mid busy", 64'(BUSY), 64'd1);
        RST = 1'b1;
        @(posedge CLK); #1;
        exp_prod = '0;
        check("midreset product", PRODUCT, 64'd0);
        check("midreset busy", 64'(BUSY), 64'd0);
        check("midreset done", 64'(DONE), 64'd0);
        RST = 1'b0;
        run_mul(32'd9, 32'd9, 1'b0, "after reset 9x9");
        check("9x9 value", PRODUCT, 64'd81);
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            check("post idle", {PRODUCT[61:0], BUSY, DONE}, {64'd81} << 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
